// File: rtl/lii_protocol_checker_if.sv
// LII stream bundle snooped by lii_protocol_checker.
//   sof, eof, eeof : framing strobes
//   edb            : early valid-byte count, meaningful with eeof
//   bytes_vld      : valid bytes on an eof beat
//   rdy            : beat qualifier; a beat is a cycle with rdy=1
// master drives the stream, slave observes it.
interface lii_protocol_checker_if #(
  parameter int DATA_WIDTH = 64
);
  localparam int BV_W = $clog2(DATA_WIDTH / 8) + 1;

  logic            sof;
  logic            eof;
  logic            eeof;
  logic [BV_W-1:0] edb;
  logic [BV_W-1:0] bytes_vld;
  logic            rdy;

  modport master (output sof, eof, eeof, edb, bytes_vld, rdy);
  modport slave  (input  sof, eof, eeof, edb, bytes_vld, rdy);
endinterface

// File: rtl/lii_protocol_checker.sv
// Passive LII protocol checker. Snoops one LII stream and reports framing,
// EEOF/EDB and frame-length violations.
//   clk, rst   : clock, asynchronous active-high reset
//   lii        : snooped stream (slave modport)
//   clear      : synchronous clear of sticky flags, counters and last_len
//   err_pulse  : one-cycle pulse per offending beat, one bit per error
//                0 SOF_IN_FRAME, 1 ORPHAN_EOF, 2 EOF_MISSING, 3 EDB_MISMATCH,
//                4 BV_RANGE, 5 LEN_MIN, 6 LEN_MAX, 7 DATA_OUTSIDE
//   err_sticky : OR-accumulation of err_pulse
//   err_cnt    : beats carrying at least one error (saturating)
//   frame_cnt  : frames closed by EOF inside a frame (saturating)
//   last_len   : length in bytes of the last closed frame
//   in_frame   : tracker is not idle
module lii_protocol_checker #(
  parameter int DATA_WIDTH = 64,
  parameter bit FAST_SOF   = 1'b1,
  parameter bit CHECK_IDLE = 1'b0,
  parameter int LEN_WIDTH  = 16,
  parameter int MIN_LEN    = 60,
  parameter int MAX_LEN    = 1526,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lii_protocol_checker_if.slave lii,
  input  logic                  clear,
  output logic [7:0]            err_pulse,
  output logic [7:0]            err_sticky,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [LEN_WIDTH-1:0]  last_len,
  output logic                  in_frame
);
  localparam int BPB  = DATA_WIDTH / 8;
  localparam int BV_W = $clog2(BPB) + 1;
  localparam logic [LEN_WIDTH-1:0] BPB_LEN = LEN_WIDTH'(BPB);
  localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_LEN);
  localparam logic [BV_W-1:0]      BPB_BV  = BV_W'(BPB);

  typedef enum logic [1:0] {ST_IDLE, ST_IN_FRAME, ST_WAIT_EOF} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_cnt, len_nxt;
  logic [BV_W-1:0]      edb_q, edb_nxt;
  logic [7:0]           err;
  logic                 close;
  logic [LEN_WIDTH-1:0] close_base, close_len;

  function automatic logic [LEN_WIDTH-1:0] len_add(input logic [LEN_WIDTH-1:0] a,
                                                   input logic [LEN_WIDTH-1:0] b);
    logic [LEN_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : s[LEN_WIDTH-1:0];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // len_cnt holds the bytes of full beats already seen in the current frame,
  // so an EOF beat closes with len_cnt + bytes_vld.
  always_comb begin
    err        = '0;
    state_nxt  = state;
    len_nxt    = len_cnt;
    edb_nxt    = edb_q;
    close      = 1'b0;
    close_base = len_cnt;
    close_len  = '0;
    if (lii.rdy) begin
      if (state == ST_WAIT_EOF) begin
        if (!lii.eof)                          err[2] = 1'b1;
        else if (lii.bytes_vld != edb_q)       err[3] = 1'b1;
      end
      if (lii.sof) begin
        // A SOF always starts a fresh frame; an open one is dropped uncounted.
        if (state != ST_IDLE) err[0] = 1'b1;
        if (lii.eof) begin
          close      = 1'b1;
          close_base = '0;
        end else begin
          len_nxt = BPB_LEN;
          if (FAST_SOF && lii.eeof) begin
            state_nxt = ST_WAIT_EOF;
            edb_nxt   = lii.edb;
          end else begin
            state_nxt = ST_IN_FRAME;
          end
        end
      end else if (state == ST_IDLE) begin
        if (lii.eof) err[1] = 1'b1;
        else         err[7] = CHECK_IDLE;
      end else if (lii.eof) begin
        close = 1'b1;
      end else begin
        len_nxt = len_add(len_cnt, BPB_LEN);
        if (FAST_SOF && lii.eeof) begin
          state_nxt = ST_WAIT_EOF;
          edb_nxt   = lii.edb;
        end else begin
          state_nxt = ST_IN_FRAME;
        end
      end
      if (close) begin
        close_len = len_add(close_base, LEN_WIDTH'(lii.bytes_vld));
        if (lii.bytes_vld == '0 || lii.bytes_vld > BPB_BV) err[4] = 1'b1;
        if (close_len < MIN_L) err[5] = 1'b1;
        if (close_len > MAX_L) err[6] = 1'b1;
        state_nxt = ST_IDLE;
        len_nxt   = '0;
      end
    end
  end

  // Registered outputs: everything reflects the beat sampled on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_cnt    <= '0;
      edb_q      <= '0;
      err_pulse  <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
      last_len   <= '0;
    end else begin
      state     <= state_nxt;
      len_cnt   <= len_nxt;
      edb_q     <= edb_nxt;
      err_pulse <= err;
      if (clear) begin
        err_sticky <= '0;
        err_cnt    <= '0;
        frame_cnt  <= '0;
        last_len   <= '0;
      end else begin
        err_sticky <= err_sticky | err;
        if (|err) err_cnt <= cnt_inc(err_cnt);
        if (close) begin
          frame_cnt <= cnt_inc(frame_cnt);
          last_len  <= close_len;
        end
      end
    end
  end

  assign in_frame = (state != ST_IDLE);
endmodule

// File: tb/tb_lii_protocol_checker.sv
module tb_lii_protocol_checker;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  err_pulse, err_sticky, i_err_pulse, i_err_sticky;
  logic [31:0] err_cnt, frame_cnt, i_err_cnt, i_frame_cnt;
  logic [15:0] last_len, i_last_len;
  logic        in_frame, i_in_frame;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  always #5 clk = ~clk;

  lii_protocol_checker_if #(.DATA_WIDTH(DW)) lii ();

  lii_protocol_checker #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .lii(lii), .clear(clear),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .frame_cnt(frame_cnt), .last_len(last_len), .in_frame(in_frame)
  );

  lii_protocol_checker #(.DATA_WIDTH(DW), .CHECK_IDLE(1'b1)) dut_idle (
    .clk(clk), .rst(rst), .lii(lii), .clear(clear),
    .err_pulse(i_err_pulse), .err_sticky(i_err_sticky), .err_cnt(i_err_cnt),
    .frame_cnt(i_frame_cnt), .last_len(i_last_len), .in_frame(i_in_frame)
  );

  // One clock of stimulus; the expected err_pulse for this beat goes to the
  // scoreboard and the observed one is captured one edge later.
  task automatic drive(input logic s, input logic e, input logic ee,
                       input logic [3:0] ed, input logic [3:0] bv,
                       input logic r, input logic [7:0] exp);
    lii.sof = s; lii.eof = e; lii.eeof = ee;
    lii.edb = ed; lii.bytes_vld = bv; lii.rdy = r;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    obs_q.push_back(err_pulse);
    lii.rdy = 1'b0;
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 4'd0, 4'd0, 1, 8'h00);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive(0, 0, 0, 4'd0, 4'd0, 0, 8'h00);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    lii.sof = 0; lii.eof = 0; lii.eeof = 0; lii.edb = 0; lii.bytes_vld = 0; lii.rdy = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if ({err_pulse, err_sticky} !== 16'h0) begin bad++; $display("FAIL reset_err: got %h want 0000", {err_pulse, err_sticky}); end
    total++; if ({err_cnt, frame_cnt} !== 64'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", {err_cnt, frame_cnt}); end
    total++; if ({last_len, in_frame} !== 17'h0) begin bad++; $display("FAIL reset_len: got %h want 0", {last_len, in_frame}); end
  endtask

  task automatic test_basic();
    logic [7:0] e, o;
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00);
    plain(5);
    drive(0, 0, 1, 4'd8, 4'd0, 1, 8'h00);
    total++; if (in_frame !== 1'b1) begin bad++; $display("FAIL basic_in_frame: got %b want 1", in_frame); end
    drive(0, 1, 0, 4'd0, 4'd8, 1, 8'h00);
    plain(0);
    drive(0, 0, 0, 4'd0, 4'd0, 0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL basic_pulse: got %h want %h", o, e); end
    end
    total++; if (frame_cnt !== 32'd1) begin bad++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
    total++; if (last_len !== 16'd64) begin bad++; $display("FAIL basic_last_len: got %0d want 64", last_len); end
    total++; if (err_sticky !== 8'h00) begin bad++; $display("FAIL basic_sticky: got %h want 00", err_sticky); end
    total++; if (in_frame !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", in_frame); end
  endtask

  task automatic test_sof_in_frame();
    logic [7:0] e, o;
    do_clear();
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00);
    plain(2);
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h01);
    plain(6);
    drive(0, 1, 0, 4'd0, 4'd8, 1, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL sof_pulse: got %h want %h", o, e); end
    end
    total++; if (err_cnt !== 32'd1) begin bad++; $display("FAIL sof_err_cnt: got %0d want 1", err_cnt); end
    total++; if (frame_cnt !== 32'd1) begin bad++; $display("FAIL sof_frame_cnt: got %0d want 1", frame_cnt); end
    total++; if (last_len !== 16'd64) begin bad++; $display("FAIL sof_last_len: got %0d want 64", last_len); end
    total++; if (err_sticky !== 8'h01) begin bad++; $display("FAIL sof_sticky: got %h want 01", err_sticky); end
  endtask

  task automatic test_edb();
    logic [7:0] e, o;
    do_clear();
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00);
    plain(6);
    drive(0, 0, 1, 4'd5, 4'd0, 1, 8'h00);
    drive(1, 1, 1, 4'd0, 4'd0, 0, 8'h00);  // ignored: rdy low
    drive(1, 1, 1, 4'd0, 4'd0, 0, 8'h00);
    drive(0, 1, 0, 4'd0, 4'd3, 1, 8'h08);
    total++; if (last_len !== 16'd67) begin bad++; $display("FAIL edb_last_len: got %0d want 67", last_len); end
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00);
    plain(6);
    drive(0, 0, 1, 4'd8, 4'd0, 1, 8'h00);
    drive(0, 0, 0, 4'd0, 4'd0, 1, 8'h04);
    drive(0, 1, 0, 4'd0, 4'd8, 1, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL edb_pulse: got %h want %h", o, e); end
    end
    total++; if (err_sticky !== 8'h0C) begin bad++; $display("FAIL edb_sticky: got %h want 0c", err_sticky); end
    total++; if (err_cnt !== 32'd2) begin bad++; $display("FAIL edb_err_cnt: got %0d want 2", err_cnt); end
    total++; if ({frame_cnt[15:0], last_len} !== {16'd2, 16'd80}) begin bad++; $display("FAIL edb_frame: got %h want 00020050", {frame_cnt[15:0], last_len}); end
  endtask

  task automatic test_len();
    logic [7:0] e, o;
    do_clear();
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00); plain(5); drive(0, 1, 0, 4'd0, 4'd2, 1, 8'h20);
    total++; if (last_len !== 16'd50) begin bad++; $display("FAIL len_50: got %0d want 50", last_len); end
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00); plain(6); drive(0, 1, 0, 4'd0, 4'd0, 1, 8'h30);
    total++; if (last_len !== 16'd56) begin bad++; $display("FAIL len_56: got %0d want 56", last_len); end
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00); plain(6); drive(0, 1, 0, 4'd0, 4'd4, 1, 8'h00);
    total++; if (last_len !== 16'd60) begin bad++; $display("FAIL len_60: got %0d want 60", last_len); end
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00); plain(7); drive(0, 1, 0, 4'd0, 4'd9, 1, 8'h10);
    total++; if (last_len !== 16'd73) begin bad++; $display("FAIL len_73: got %0d want 73", last_len); end
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00); plain(190); drive(0, 1, 0, 4'd0, 4'd8, 1, 8'h40);
    total++; if (last_len !== 16'd1536) begin bad++; $display("FAIL len_1536: got %0d want 1536", last_len); end
    drive(1, 1, 0, 4'd0, 4'd8, 1, 8'h20);
    total++; if (last_len !== 16'd8) begin bad++; $display("FAIL len_single: got %0d want 8", last_len); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL len_pulse: got %h want %h", o, e); end
    end
    total++; if (err_cnt !== 32'd5) begin bad++; $display("FAIL len_err_cnt: got %0d want 5", err_cnt); end
    total++; if (frame_cnt !== 32'd6) begin bad++; $display("FAIL len_frame_cnt: got %0d want 6", frame_cnt); end
    total++; if (err_sticky !== 8'h70) begin bad++; $display("FAIL len_sticky: got %h want 70", err_sticky); end
  endtask

  task automatic test_idle();
    logic [7:0] e, o;
    drive(0, 0, 0, 4'd0, 4'd0, 1, 8'h00);
    total++; if (i_err_pulse !== 8'h80) begin bad++; $display("FAIL idle_data: got %h want 80", i_err_pulse); end
    drive(0, 0, 1, 4'd3, 4'd0, 1, 8'h00);  // EEOF without SOF in idle is ignored
    total++; if (in_frame !== 1'b0) begin bad++; $display("FAIL idle_eeof: got %b want 0", in_frame); end
    drive(0, 0, 0, 4'd0, 4'd0, 0, 8'h00);
    total++; if (i_err_pulse !== 8'h00) begin bad++; $display("FAIL idle_gap: got %h want 00", i_err_pulse); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL idle_pulse: got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e, o;
    drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00);
    plain(2);
    rst = 1'b1; #2 rst = 1'b0;
    total++; if ({in_frame, frame_cnt} !== 33'h0) begin bad++; $display("FAIL rst_mid: got %h want 0", {in_frame, frame_cnt}); end
    drive(0, 1, 0, 4'd0, 4'd8, 1, 8'h02);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rst_pulse: got %h want %h", o, e); end
    end
    total++; if (frame_cnt !== 32'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    total++; if (err_sticky !== 8'h02) begin bad++; $display("FAIL rst_sticky: got %h want 02", err_sticky); end
  endtask

  task automatic test_clear_same_cycle();
    logic [7:0] e, o;
    clear = 1'b1;
    drive(0, 1, 0, 4'd0, 4'd8, 1, 8'h02);
    clear = 1'b0;
    total++; if ({err_sticky, err_cnt} !== 40'h0) begin bad++; $display("FAIL clear_same: got %h want 0", {err_sticky, err_cnt}); end
    drive(0, 0, 0, 4'd0, 4'd0, 0, 8'h00);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL clear_pulse: got %h want %h", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    for (int f = 0; f < 2; f++) begin
      drive(1, 0, 0, 4'd0, 4'd0, 1, 8'h00);
      plain(6);
      drive(0, 1, 0, 4'd0, 4'd4 + 4'(f), 1, 8'h00);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b_pulse: got %h want %h", o, e); end
    end
    total++; if (frame_cnt !== 32'd2) begin bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
    total++; if (last_len !== 16'd61) begin bad++; $display("FAIL b2b_last_len: got %0d want 61", last_len); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sof_in_frame();
    test_edb();
    test_len();
    test_idle();
    test_reset_mid_frame();
    test_clear_same_cycle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
